sha256_compress: RTL and testbench
==================================

# sha256_compress

SHA-256 compression core: the responder side of the block-hash handshake that the HMAC sequencers drive. The core takes one 512-bit message block and a 256-bit chaining value, runs 64 rounds at one round per cycle, and returns the updated chaining value with a one-cycle done pulse. It sits under every hmac_sha256_* sequencer and any PBKDF2/scrypt front end that needs raw compressions. Padding and multi-block sequencing belong to the requester.

## Interface
- Parameters: none; round count and constants are fixed by FIPS 180-4.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  request; sampled only in IDLE
- data  in  512  message block; data[511:480] = W0 … data[31:0] = W15, big-endian words
- current_hash  in  256  chaining input; [255:224] = H0 … [31:0] = H7
- hash  out  256  last completed result, same word order; held until the next completion
- hash_done  out  1  one-cycle pulse, high while `hash` carries a newly written result
- busy  out  1  high in ROUND, FINAL and DONE

## Operation
- States:
  - IDLE. If enable=1 at an edge: latch data into a 16-word schedule window, latch current_hash into H_in, load a..h = H_in, set round counter t = 0, go to ROUND.
  - ROUND. Each edge applies one round using K[t] and W_t, then increments t. W_t for t<16 comes from the window; for t≥16, W_t = σ1(W_t-2) + W_t-7 + σ0(W_t-15) + W_t-16, and the window shifts one word per edge. At the edge where t=63, go to FINAL.
  - FINAL. hash <= H_in + {a..h}, word-wise mod 2^32. Go to DONE.
  - DONE. hash_done = 1. Go to IDLE unconditionally.
- Inputs are latched at launch, so later changes to data or current_hash are ignored. Requesters feed `hash` straight back into current_hash; this is legal.
- enable is ignored outside IDLE. Dropping it mid-block does not abort the block.
- A launch is never taken in DONE. The requester changes data on the edge that ends DONE, so an enable still held high launches on the following IDLE edge with the fresh block.
- All additions are 32-bit and wrap mod 2^32 with carries discarded. Rotations are ROTR.
- rst in any state:
  - state = IDLE, t = 0
  - hash = 0, hash_done = 0, busy = 0
  - working registers cleared
  - an in-flight block is discarded with no done pulse

## Timing
- Edge 0 is the launch edge (IDLE, enable=1). Round t is written at edge t+1, for t = 0..63.
- FINAL writes hash at edge 65. hash_done is high for exactly the cycle between edges 65 and 66.
- State returns to IDLE at edge 66. The earliest next launch is edge 67, so throughput is one block per 67 cycles.
- hash changes only at edge 65 of a block, or on reset.
- hash_done and busy are registered or decoded only from the state register. Neither has a combinational path from enable.

## Structure
- Package sha256_pkg holds:
  - the state enum (IDLE, ROUND, FINAL, DONE)
  - the 64×32 K table
  - the FIPS IV constant
  - functions Ch, Maj, Σ0, Σ1, σ0, σ1
  - The HMAC sequencers import the IV from this package.
- One sub-module, sha256_round: a combinational round taking {a..h}, K_t and W_t and producing the next {a..h}.
- The schedule window and the FSM live in sha256_compress.

## Test plan
- **"abc" block.** data = 0x61626380, 13 zero words, 0x00000018; current_hash = IV; pulse enable. Required: hash_done at edge 65 → hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; busy low after edge 66.
- **Empty message.** data = 0x80000000 followed by 15 zero words; current_hash = IV. Required: hash = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- **Two-block chain.** Input is "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", padded to two blocks. Hold enable high throughout, with current_hash wired to hash for block 2 and data switched on the DONE edge. Required:
  - second pulse 67 cycles after the first
  - final hash = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1
- **Input perturbation.** Randomize data and current_hash every cycle during ROUND. Required: "abc" result unchanged; enable pulses during busy ignored, exactly one hash_done.
- **Reset mid-block.** Assert rst at t = 30. Required:
  - next cycle: hash = 0, hash_done = 0, busy = 0
  - no done pulse for the aborted block
  - a subsequent "abc" launch yields the correct digest at edge 65
- **Idle hold.** enable = 0 for 100 cycles after a completion. Required: hash stable, hash_done stays 0, busy stays 0.

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, FSM states and round helper functions
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Rotations written as explicit slices so every term is exactly 32 bits.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 round over the {a..h} working set
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  k_i,
  input  logic [31:0]  w_i,
  output logic [255:0] state_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - SHA-256 compression core, one round per cycle
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [511:0] data,
  input  logic [255:0] current_hash,
  output logic [255:0] hash,
  output logic         hash_done,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [5:0]   t_q, t_d;
  logic [511:0] win_q, win_d;
  logic [255:0] hin_q, hin_d;
  logic [255:0] work_q, work_d;
  logic [255:0] hash_q, hash_d;

  logic [255:0] work_next;
  logic [31:0]  w_t;
  logic [31:0]  w_new;

  // The window always presents W_t in its top word; the word appended at the
  // bottom is W_{t+16}, so the first 16 rounds consume the latched block as-is.
  assign w_t   = win_q[511:480];
  assign w_new = small_sigma1(win_q[63:32]) + win_q[223:192]
               + small_sigma0(win_q[479:448]) + win_q[511:480];

  sha256_round u_round (
    .state_i (work_q),
    .k_i     (K[t_q]),
    .w_i     (w_t),
    .state_o (work_next)
  );

  // Next-state, schedule window and result update.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    win_d   = win_q;
    hin_d   = hin_q;
    work_d  = work_q;
    hash_d  = hash_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          win_d   = data;
          hin_d   = current_hash;
          work_d  = current_hash;
          t_d     = 6'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d = work_next;
        win_d  = {win_q[479:0], w_new};
        t_d    = t_q + 6'd1;
        if (t_q == 6'd63) state_d = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) begin
          hash_d[32*i +: 32] = hin_q[32*i +: 32] + work_q[32*i +: 32];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      win_q   <= '0;
      hin_q   <= '0;
      work_q  <= '0;
      hash_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      win_q   <= win_d;
      hin_q   <= hin_d;
      work_q  <= work_d;
      hash_q  <= hash_d;
    end
  end

  assign hash      = hash_q;
  assign hash_done = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sha256_compress.sv
// tb/tb_sha256_compress.sv - directed self-checking bench for sha256_compress
module tb_sha256_compress;
  import sha256_pkg::*;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] ABC_H = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_H = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] TWO_H = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [511:0] data;
  logic [255:0] cur_reg;
  logic         chain;
  logic [255:0] current_hash;
  logic [255:0] hash;
  logic         hash_done;
  logic         busy;

  int checks = 0;
  int errors = 0;

  assign current_hash = chain ? hash : cur_reg;

  always #5 clk = ~clk;

  sha256_compress dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .data         (data),
    .current_hash (current_hash),
    .hash         (hash),
    .hash_done    (hash_done),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until hash_done is seen; n is the number of edges taken (capped).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!hash_done && n < 200);
  endtask

  task automatic launch(input logic [511:0] blk, input logic [255:0] h);
    data    = blk;
    cur_reg = h;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; chain = 1'b0; data = '0; cur_reg = '0;
    tick(); tick();
    checks++;
    if (hash !== 256'h0) begin errors++; $display("FAIL reset_hash: got %h want 0", hash); end
    checks++;
    if (hash_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", hash_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_abc();
    int n;
    launch(ABC_BLK, IV);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abc_busy_after_launch: got %b want 1", busy); end
    wait_done(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL abc_latency: got %0d want 65", n); end
    checks++;
    if (hash !== ABC_H) begin errors++; $display("FAIL abc_hash: got %h want %h", hash, ABC_H); end
    tick();
    checks++;
    if (busy !== 1'b0 || hash_done !== 1'b0) begin
      errors++; $display("FAIL abc_after_done: busy=%b done=%b want 0 0", busy, hash_done);
    end
  endtask

  task automatic test_empty();
    int n;
    launch(EMPTY_BLK, IV);
    wait_done(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL empty_latency: got %0d want 65", n); end
    checks++;
    if (hash !== EMPTY_H) begin errors++; $display("FAIL empty_hash: got %h want %h", hash, EMPTY_H); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    data = TWO_BLK1; cur_reg = IV; chain = 1'b0; enable = 1'b1;
    tick();
    chain = 1'b1;
    wait_done(n1);
    checks++;
    if (n1 !== 65) begin errors++; $display("FAIL chain_first_latency: got %0d want 65", n1); end
    data = TWO_BLK2;
    wait_done(n2);
    checks++;
    if (n2 !== 67) begin errors++; $display("FAIL chain_pulse_spacing: got %0d want 67", n2); end
    checks++;
    if (hash !== TWO_H) begin errors++; $display("FAIL chain_hash: got %h want %h", hash, TWO_H); end
    enable = 1'b0;
    chain = 1'b0;
    tick(); tick();
  endtask

  task automatic test_perturb();
    int pulses, at;
    logic [255:0] got;
    pulses = 0; at = -1; got = '0;
    launch(ABC_BLK, IV);
    for (int i = 0; i < 75; i++) begin
      if (pulses == 0) begin
        for (int w = 0; w < 16; w++) data[32*w +: 32] = $urandom;
        for (int w = 0; w < 8; w++) cur_reg[32*w +: 32] = $urandom;
        enable = 1'($urandom_range(0, 1));
      end else begin
        enable = 1'b0;
      end
      tick();
      if (hash_done) begin
        pulses++;
        if (pulses == 1) begin at = i + 1; got = hash; end
      end
    end
    enable = 1'b0;
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL perturb_pulses: got %0d want 1", pulses); end
    checks++;
    if (at !== 65) begin errors++; $display("FAIL perturb_latency: got %0d want 65", at); end
    checks++;
    if (got !== ABC_H) begin errors++; $display("FAIL perturb_hash: got %h want %h", got, ABC_H); end
  endtask

  task automatic test_reset_mid_block();
    int n, pulses;
    launch(ABC_BLK, IV);
    for (int i = 0; i < 30; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (hash !== 256'h0 || hash_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset_clear: hash=%h done=%b busy=%b want 0 0 0", hash, hash_done, busy);
    end
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (hash_done) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midreset_no_pulse: got %0d want 0", pulses); end
    launch(ABC_BLK, IV);
    wait_done(n);
    checks++;
    if (n !== 65) begin errors++; $display("FAIL midreset_relaunch_latency: got %0d want 65", n); end
    checks++;
    if (hash !== ABC_H) begin errors++; $display("FAIL midreset_relaunch_hash: got %h want %h", hash, ABC_H); end
    tick();
  endtask

  task automatic test_idle_hold();
    logic [255:0] held;
    enable = 1'b0;
    held = ABC_H;
    for (int i = 0; i < 100; i++) begin
      data = {16{32'($urandom)}};
      tick();
      checks++;
      if (hash !== held || hash_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: hash=%h done=%b busy=%b want %h 0 0", i, hash, hash_done, busy, held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_back_to_back();
    test_perturb();
    test_reset_mid_block();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
